led_run_scheduler: RTL and testbench

//   Shares one LED counting datapath between N_REQ requesters (e.g. go buttons).

---
 rtl/led_run_scheduler.sv | 138 +++++++++++++
 tb/tb_led_run_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_run_scheduler.sv
// Round-robin scheduler sharing one LED counting datapath between N_REQ requesters.
// Each granted run counts led 0..max at one step per TICK_DIV clocks, then pulses done.
module led_run_scheduler #(
   parameter int unsigned N_REQ    = 2,
   parameter int unsigned LED_W    = 4,
   parameter int unsigned TICK_DIV = 15000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [N_REQ-1:0] done,
   output logic [LED_W-1:0] led
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   localparam int unsigned IDX_W = $clog2(N_REQ);

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [LED_W-1:0] LED_MAX   = '1;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   logic [IDX_W-1:0] last_idx;
   logic [IDX_W-1:0] owner_idx;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic [N_REQ-1:0] win_onehot;
   logic             win_valid;

   // Scan starts just past the previous owner so every held request is served within N_REQ runs.
   always_comb begin
      win_valid  = 1'b0;
      win_idx    = '0;
      cand       = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         cand = IDX_W'((32'(last_idx) + off) % N_REQ);
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
      win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
   end

   assign tick = (state == ST_RUN) && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (win_valid) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (tick && (led == LED_MAX)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant     <= '0;
         led       <= '0;
         tick_cnt  <= '0;
         owner_idx <= '0;
         last_idx  <= IDX_LAST;
      end else begin
         case (state)
            ST_IDLE: begin
               led      <= '0;
               tick_cnt <= '0;
               if (win_valid) begin
                  grant     <= win_onehot;
                  owner_idx <= win_idx;
               end
            end
            ST_RUN: begin
               tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
               if (tick && (led != LED_MAX)) begin
                  led <= led + LED_W'(1);
               end
            end
            ST_DONE: begin
               grant    <= '0;
               led      <= '0;
               tick_cnt <= '0;
               last_idx <= owner_idx;
            end
            default: begin
               grant    <= '0;
               led      <= '0;
               tick_cnt <= '0;
            end
         endcase
      end
   end

   // busy/done decode straight from state so an async reset clears them with it.
   always_comb begin
      busy = (state == ST_RUN) || (state == ST_DONE);
      done = (state == ST_DONE) ? grant : '0;
   end

   a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_done_onehot  : assert property (@(posedge clk) disable iff (rst) $onehot0(done));
   a_done_state   : assert property (@(posedge clk) disable iff (rst)
                                     (done != '0) |-> (state == ST_DONE));

endmodule

// File: tb/tb_led_run_scheduler.sv
// Randomized and directed bench for led_run_scheduler against a run-level reference model.
module tb_led_run_scheduler;

   localparam int N_REQ    = 2;
   localparam int LED_W    = 2;
   localparam int TICK_DIV = 4;
   localparam int RUN_LEN  = (1 << LED_W) * TICK_DIV;
   localparam int LED_MAX  = (1 << LED_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_REQ-1:0] req = 2'b11;
   logic [N_REQ-1:0] grant;
   logic             busy;
   logic [N_REQ-1:0] done;
   logic [LED_W-1:0] led;

   int n_checks = 0;
   int n_errs   = 0;

   led_run_scheduler #(
      .N_REQ   (N_REQ),
      .LED_W   (LED_W),
      .TICK_DIV(TICK_DIV)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .grant(grant),
      .busy (busy),
      .done (done),
      .led  (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a run is "active" with e cycles elapsed since grant; e==RUN_LEN is the done cycle.
   bit m_active = 1'b0;
   int m_owner  = 0;
   int m_e      = 0;
   int m_last   = N_REQ - 1;

   function automatic int pick_rr(input logic [N_REQ-1:0] r, input int last);
      for (int k = 1; k <= N_REQ; k++) begin
         if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_e      <= 0;
         m_last   <= N_REQ - 1;
      end else if (!m_active) begin
         if (req != '0) begin
            m_active <= 1'b1;
            m_owner  <= pick_rr(req, m_last);
            m_e      <= 0;
         end
      end else if (m_e == RUN_LEN) begin
         m_active <= 1'b0;
         m_last   <= m_owner;
      end else begin
         m_e <= m_e + 1;
      end
   end

   int          cyc = 0;
   int          rise_cyc = 0;
   logic [N_REQ-1:0] prev_grant = '0;

   always @(negedge clk) begin
      int eg, eb, ed, el;
      cyc++;
      eg = m_active ? (1 << m_owner) : 0;
      eb = m_active ? 1 : 0;
      ed = (m_active && m_e == RUN_LEN) ? (1 << m_owner) : 0;
      el = !m_active ? 0 : (m_e >= RUN_LEN ? LED_MAX : m_e / TICK_DIV);
      check("grant", 32'(grant), 32'(eg));
      check("busy",  32'(busy),  32'(eb));
      check("done",  32'(done),  32'(ed));
      check("led",   32'(led),   32'(el));
      if (grant != '0 && prev_grant == '0) rise_cyc = cyc;
      if (done != '0) check("latency", 32'(cyc - rise_cyc), 32'(RUN_LEN));
      prev_grant = grant;
   end

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic async_reset_pulse();
      #3 rst = 1'b1;
      #1;
      check("async_grant", 32'(grant), 32'd0);
      check("async_busy",  32'(busy),  32'd0);
      check("async_led",   32'(led),   32'd0);
      check("async_done",  32'(done),  32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [N_REQ-1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      int n;
      logic [N_REQ-1:0] pg;

      repeat (4) @(negedge clk);
      rst = 1'b0;

      // Held requests alternate owners with a one-cycle idle gap.
      n  = 0;
      pg = '0;
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk);
         if (grant != '0 && pg == '0) begin
            check($sformatf("rr_run%0d", n), 32'(grant), 32'(rr_exp[n]));
            n++;
         end
         pg = grant;
      end
      check("rr_runs", 32'(n), 32'd4);
      req = 2'b00;
      wait_idle(40);

      // Single-cycle pulse on req[0].
      @(negedge clk);
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      check("pulse_grant", 32'(grant), 32'd1);
      wait_idle(40);
      repeat (3) @(negedge clk);

      // Owner drops its request mid-run while the other waits.
      req = 2'b01;
      repeat (3) @(negedge clk);
      req = 2'b11;
      repeat (3) @(negedge clk);
      req = 2'b10;
      for (int i = 0; i < 40 && done == '0; i++) @(negedge clk);
      check("drop_done", 32'(done), 32'd1);
      @(negedge clk);
      check("drop_gap", 32'(grant), 32'd0);
      @(negedge clk);
      check("drop_next", 32'(grant), 32'd2);
      req = 2'b00;
      wait_idle(40);

      // Async reset in the middle of a run.
      @(negedge clk);
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      for (int i = 0; i < 60 && led != 2'd2; i++) @(negedge clk);
      check("wait_led2", 32'(led), 32'd2);
      async_reset_pulse();
      repeat (10) @(negedge clk);

      // First request after reset only from req[1]; then both.
      req = 2'b10;
      @(negedge clk);
      req = 2'b00;
      check("first_grant", 32'(grant), 32'd2);
      wait_idle(40);
      req = 2'b11;
      @(negedge clk);
      check("second_grant", 32'(grant), 32'd1);
      req = 2'b00;
      wait_idle(40);

      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) async_reset_pulse();
      end

      req = 2'b00;
      wait_idle(40);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
